alu_session_arbiter: RTL
========================

Name: alu_session_arbiter

Overview:
- Shares one accumulating 8-bit ALU between two requesters.
- Grants the ALU per session. A session is a chain of ops that ends with an op flagged `last`.
- Clears the ALU at the start of each session, streams the owner's ops one per cycle, and returns each result on a shared response bus tagged with the requester id.
- Holds the ALU accumulator during owner bubbles. Aborts sessions that stall too long.

Parameters:
- W, 8, operand/result width.
- TIMEOUT, 16, consecutive bubble cycles in RUN before abort; 0 disables the watchdog.
- TW, 5, width of the bubble counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- req0_valid, req1_valid  in  1  op offered.
- req0_ready, req1_ready  out  1  op accepted this cycle.
- req0_opcode, req1_opcode  in  3  ALU opcode: 001 ADD, 010 SUB, 011 MUL, 100 AND, 101 OR, 110 NOT, 111 XOR.
- req0_a, req1_a  in  W  operand 1.
- req0_b, req1_b  in  W  operand 2 (used only where the ALU is unchained).
- req0_last, req1_last  in  1  final op of the session.
- alu_clear  out  1  ALU clear.
- alu_opcode  out  3  opcode to the ALU.
- alu_in1, alu_in2  out  W  operands to the ALU.
- alu_out  in  W  ALU result, combinational in the issue cycle.
- rsp_valid  out  1  result pulse.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  W  result.
- abort  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async, clear_n=0): state=IDLE, owner=0, prio=0, bubble_cnt=0. Outputs: rsp_valid=0, rsp_id=0, rsp_data=0, abort=0, both readies=0.
- States and transitions:
  - IDLE: alu_clear=1, alu_opcode=000, operands 0, readies 0.
    - If any reqN_valid: owner <= winner; go to CLEAR.
    - Winner is prio when both are valid, otherwise the single valid requester.
  - CLEAR: alu_clear=1 for exactly one cycle; go to RUN; bubble_cnt<=0.
  - RUN: alu_clear=0; req<owner>_ready=1; the other ready=0.
    - Accept (owner valid): alu_opcode/in1/in2 = owner's opcode/a/b. rsp_data<=alu_out, rsp_id<=owner, rsp_valid<=1 (registered, so 1 cycle after accept). bubble_cnt<=0.
    - Accept with last: next state IDLE, prio <= ~owner.
    - Bubble (owner valid=0): drive filler alu_opcode=101 (OR), alu_in1=0, alu_in2=0. This preserves the ALU accumulator. bubble_cnt++.
    - If bubble_cnt reaches TIMEOUT (TIMEOUT≠0) on a bubble cycle: abort<=1 next cycle, state IDLE, prio <= ~owner.
- rsp_valid and abort are single-cycle pulses. Neither is ever high in the same cycle as the other.
- Non-owner requests are held (ready=0) for the whole session. There is no preemption.
- Turnaround is 2 cycles: the owner's last accept, then IDLE, then CLEAR, then the first accept of the next session. The minimum clear-to-first-op distance is 1 cycle.
- Fairness: a requester continuously valid gets the next session after the current one ends.
- Simultaneous valid in IDLE: prio wins.
- Owner drops valid then re-raises it before timeout: the session continues; bubble_cnt resets.
- Reset mid-session: immediate IDLE with alu_clear=1. No rsp_valid is emitted for in-flight ops.
- Opcode 000 from a requester: passed through unchanged (the ALU outputs 0), and a response is still returned.
- Widths: all operand paths are W bits, with no extension or truncation in this block.

Decomposition:
- Shared package/include `alu_defs`: opcode constants OP_ADD..OP_XOR, OP_FILL=OP_OR, and the state encoding IDLE=2'd0, CLEAR=2'd1, RUN=2'd2.
- One sub-module, `rr_pick2`: 2-way round-robin select, with inputs valid[1:0] and prio and outputs grant_id and any.
- The FSM, operand muxing, watchdog and response register stay in the top module.

Test Plan:
- Single session, bench connected to the real ALU: req0 sends ADD a=3 b=4 last=1.
  - Response: alu_clear high for IDLE+CLEAR, accept in the 3rd cycle, then rsp_valid=1, rsp_id=0, rsp_data=7.
  - busy returns to 0.
- Contention: req0 and req1 both valid in IDLE after reset. Each sends 2 ops (MUL 2×3, then last).
  - req0 is served first (prio=0) and req1 is held with ready=0 throughout.
  - Both of req0's rsp_id are 0; the first rsp_data=6.
  - Then a 2-cycle gap, then req1 served with rsp_id=1.
- Fairness: req0 continuously valid with back-to-back sessions and req1 valid. Sessions alternate 0,1,0,1.
- Bubble fill: req0 first op AND a=0xFF b=0x7E, then valid low for 3 cycles, then last op.
  - During the bubbles: alu_opcode=101, alu_in1=0, alu_in2=0, no rsp_valid, no abort.
- Watchdog with TIMEOUT=4: owner idle after its first op.
  - abort pulses exactly once, 1 cycle after the 4th bubble; state IDLE; the waiting req1 is granted next.
- Async reset mid-session: clear_n low mid-cycle during RUN.
  - Outputs immediately go to 0 and alu_clear=1.
  - After release, a fresh session starts cleanly with prio=0.

Source files
------------

// File: rtl/alu_session_arbiter_pkg.sv
// alu_session_arbiter_pkg: opcode constants and arbiter state encoding
package alu_session_arbiter_pkg;
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;
    localparam logic [2:0] OP_FILL = OP_OR;
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2} state_t;
endpackage

// File: rtl/alu_session_arbiter_if.sv
// alu_session_arbiter_if: requester, ALU and response buses of the session arbiter
interface alu_session_arbiter_if #(parameter int W = 8);
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_opcode, req1_opcode;
    logic [W-1:0] req0_a, req1_a, req0_b, req1_b;
    logic         req0_last, req1_last;
    logic         alu_clear;
    logic [2:0]   alu_opcode;
    logic [W-1:0] alu_in1, alu_in2, alu_out;
    logic         rsp_valid, rsp_id;
    logic [W-1:0] rsp_data;
    logic         abort, busy;
    modport slave (
        input  req0_valid, req1_valid, req0_opcode, req1_opcode, req0_a, req1_a,
               req0_b, req1_b, req0_last, req1_last, alu_out,
        output req0_ready, req1_ready, alu_clear, alu_opcode, alu_in1, alu_in2,
               rsp_valid, rsp_id, rsp_data, abort, busy
    );
    modport master (
        output req0_valid, req1_valid, req0_opcode, req1_opcode, req0_a, req1_a,
               req0_b, req1_b, req0_last, req1_last, alu_out,
        input  req0_ready, req1_ready, alu_clear, alu_opcode, alu_in1, alu_in2,
               rsp_valid, rsp_id, rsp_data, abort, busy
    );
endinterface

// File: rtl/alu_session_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, prio breaks ties
module rr_pick2 (
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    output logic       o_grant_id,
    output logic       o_any
);
    always_comb begin
        o_any      = |i_valid;
        o_grant_id = &i_valid ? i_prio : i_valid[1];
    end
endmodule

// File: rtl/alu_session_arbiter.sv
// alu_session_arbiter: per-session sharing of one accumulating ALU between two requesters
module alu_session_arbiter
    import alu_session_arbiter_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input logic                  clk,
    input logic                  clear_n,
    alu_session_arbiter_if.slave bus
);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
    state_t         r_state, w_next_state;
    logic           r_owner, r_prio, r_rsp_valid, r_rsp_id, r_abort;
    logic [TW-1:0]  r_bubble_cnt;
    logic [W-1:0]   r_rsp_data;
    logic           w_grant, w_any, w_run, w_accept, w_bubble, w_last, w_timeout;
    rr_pick2 u_pick (
        .i_valid    ({bus.req1_valid, bus.req0_valid}),
        .i_prio     (r_prio),
        .o_grant_id (w_grant),
        .o_any      (w_any)
    );
    always_comb begin
        w_run          = r_state == RUN;
        w_accept       = w_run && (r_owner ? bus.req1_valid : bus.req0_valid);
        w_bubble       = w_run && !w_accept;
        w_last         = r_owner ? bus.req1_last : bus.req0_last;
        w_timeout      = (TIMEOUT != 0) && w_bubble && (r_bubble_cnt == LIMIT);
        w_next_state   = r_state == IDLE  ? (w_any ? CLEAR : IDLE) :
                         r_state == CLEAR ? RUN :
                         (w_run && !(w_accept && w_last) && !w_timeout) ? RUN : IDLE;
        bus.alu_clear  = !w_run;
        bus.req0_ready = w_run && !r_owner;
        bus.req1_ready = w_run && r_owner;
        // an OR with zero during bubbles leaves the accumulator untouched
        bus.alu_opcode = w_accept ? (r_owner ? bus.req1_opcode : bus.req0_opcode) :
                         w_run ? OP_FILL : OP_NONE;
        bus.alu_in1    = w_accept ? (r_owner ? bus.req1_a : bus.req0_a) : '0;
        bus.alu_in2    = w_accept ? (r_owner ? bus.req1_b : bus.req0_b) : '0;
        bus.rsp_valid  = r_rsp_valid;
        bus.rsp_id     = r_rsp_id;
        bus.rsp_data   = r_rsp_data;
        bus.abort      = r_abort;
        bus.busy       = r_state != IDLE;
    end
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_prio       <= 1'b0;
            r_bubble_cnt <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_abort      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_rsp_valid <= w_accept;
            r_abort     <= w_timeout;
            if (r_state == IDLE && w_any) r_owner <= w_grant;
            if ((w_accept && w_last) || w_timeout) r_prio <= !r_owner;
            if (r_state == CLEAR || w_accept) r_bubble_cnt <= '0;
            else if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (w_accept) begin
                r_rsp_id   <= r_owner;
                r_rsp_data <= bus.alu_out;
            end
        end
    end
endmodule
